rtc_ctrl: RTL and testbench

- Sequencing controller for the real-time clock datapath.
- Owns the packed BCD time register (HH:MM:SS, 22 bits) and advances it once per second from a clk-derived prescaler.
- Arbitrates between second-ticks and host set-time writes, and raises an alarm on a time match.
- Sits between the system clock domain and host/config logic; time_out drives display and timestamp consumers.

---
 rtl/rtc_pkg.sv | 42 ++++
 rtl/rtc_ctrl_if.sv | 28 ++
 rtl/rtc_bcd_next.sv | 57 +++++
 rtl/rtc_ctrl.sv | 116 +++++++++++
 tb/tb_rtc_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared constants, state encoding and BCD validity helper for the
// real-time clock controller.
package rtc_pkg;

  localparam int TIME_W = 22;

  // LSB positions of each packed BCD field (hour tens is 2 bits wide).
  localparam int HR_T  = 20;
  localparam int HR_U  = 16;
  localparam int MIN_T = 12;
  localparam int MIN_U = 8;
  localparam int SEC_T = 4;
  localparam int SEC_U = 0;

  localparam logic [1:0] HR_T_MAX    = 2'd2;
  localparam logic [3:0] HR_U_MAX    = 4'd9;
  localparam logic [3:0] HR_U_MAX_20 = 4'd3;
  localparam logic [3:0] MS_T_MAX    = 4'd5;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    COMMIT  = 2'd2
  } rtc_state_e;

  function automatic logic bcd_valid(input logic [TIME_W-1:0] t);
    logic [1:0] ht;
    logic [3:0] hu, mt, mu, st, su;
    ht = t[HR_T +: 2];
    hu = t[HR_U +: 4];
    mt = t[MIN_T +: 4];
    mu = t[MIN_U +: 4];
    st = t[SEC_T +: 4];
    su = t[SEC_U +: 4];
    return (ht <= HR_T_MAX) &&
           (hu <= ((ht == HR_T_MAX) ? HR_U_MAX_20 : HR_U_MAX)) &&
           (mt <= MS_T_MAX) && (mu <= DIGIT_MAX) &&
           (st <= MS_T_MAX) && (su <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/rtc_ctrl_if.sv
// Host/config side signal bundle for rtc_ctrl; master = host, slave = controller.
interface rtc_ctrl_if;

  logic                       run_en;
  logic                       set_valid;
  logic                       set_ready;
  logic [rtc_pkg::TIME_W-1:0] set_time;
  logic                       alarm_wr;
  logic [rtc_pkg::TIME_W-1:0] alarm_time;
  logic                       alarm_en;
  logic                       alarm_clr;
  logic [rtc_pkg::TIME_W-1:0] time_out;
  logic                       sec_tick;
  logic                       alarm_irq;
  logic                       alarm_pending;
  logic                       set_err;

  modport master (
    output run_en, set_valid, set_time, alarm_wr, alarm_time, alarm_en, alarm_clr,
    input  set_ready, time_out, sec_tick, alarm_irq, alarm_pending, set_err
  );

  modport slave (
    input  run_en, set_valid, set_time, alarm_wr, alarm_time, alarm_en, alarm_clr,
    output set_ready, time_out, sec_tick, alarm_irq, alarm_pending, set_err
  );

endinterface

// File: rtl/rtc_bcd_next.sv
// Combinational next-second increment of a packed BCD HH:MM:SS value,
// plus a validity flag for the input value.
module rtc_bcd_next
  import rtc_pkg::*;
(
  input  logic [TIME_W-1:0] i_time,
  output logic [TIME_W-1:0] o_next,
  output logic              o_valid
);

  logic [1:0] w_ht;
  logic [3:0] w_hu, w_mt, w_mu, w_st, w_su;

  always_comb begin
    w_ht = i_time[HR_T +: 2];
    w_hu = i_time[HR_U +: 4];
    w_mt = i_time[MIN_T +: 4];
    w_mu = i_time[MIN_U +: 4];
    w_st = i_time[SEC_T +: 4];
    w_su = i_time[SEC_U +: 4];

    // Ripple carry digit by digit; each level only runs when the one below wrapped.
    if (w_su != DIGIT_MAX) begin
      w_su = w_su + 4'd1;
    end else begin
      w_su = '0;
      if (w_st != MS_T_MAX) begin
        w_st = w_st + 4'd1;
      end else begin
        w_st = '0;
        if (w_mu != DIGIT_MAX) begin
          w_mu = w_mu + 4'd1;
        end else begin
          w_mu = '0;
          if (w_mt != MS_T_MAX) begin
            w_mt = w_mt + 4'd1;
          end else begin
            w_mt = '0;
            if ((w_ht == HR_T_MAX) && (w_hu == HR_U_MAX_20)) begin
              w_ht = '0;
              w_hu = '0;
            end else if (w_hu == HR_U_MAX) begin
              w_hu = '0;
              w_ht = w_ht + 2'd1;
            end else begin
              w_hu = w_hu + 4'd1;
            end
          end
        end
      end
    end

    o_next  = {w_ht, w_hu, w_mt, w_mu, w_st, w_su};
    o_valid = bcd_valid(i_time);
  end

endmodule

// File: rtl/rtc_ctrl.sv
// Real-time clock sequencing controller: prescaled second ticks, host
// set-time loads with BCD checking, and a tick-driven alarm match.
module rtc_ctrl
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  rtc_ctrl_if.slave  bus
);

  localparam int          PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  rtc_state_e        r_state, w_state_nxt;
  logic [PW-1:0]     r_pre;
  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] r_alarm;
  logic              r_sec_tick;
  logic              r_alarm_irq;
  logic              r_alarm_pending;
  logic              r_set_err;

  logic [TIME_W-1:0] w_next_time;
  logic              w_cur_valid;
  logic              w_set_ready;
  logic              w_accept;
  logic              w_set_ok;
  logic              w_set_bad;
  logic              w_alarm_ok;
  logic              w_alarm_bad;
  logic              w_count;
  logic              w_wrap;
  logic              w_match;

  rtc_bcd_next u_next (
    .i_time  (r_time),
    .o_next  (w_next_time),
    .o_valid (w_cur_valid)
  );

  // The prescaler advances whenever run_en is high outside COMMIT, so the
  // STOPPED->RUN transition cycle already counts toward the first second.
  always_comb begin
    w_set_ready = (r_state != COMMIT);
    w_accept    = bus.set_valid & w_set_ready;
    w_set_ok    = w_accept & bcd_valid(bus.set_time);
    w_set_bad   = w_accept & ~bcd_valid(bus.set_time);
    w_alarm_ok  = bus.alarm_wr & bcd_valid(bus.alarm_time);
    w_alarm_bad = bus.alarm_wr & ~bcd_valid(bus.alarm_time);
    w_count     = bus.run_en & (r_state != COMMIT);
    w_wrap      = w_count & (r_pre == PRE_MAX);
    w_match     = r_sec_tick & bus.alarm_en & (r_time == r_alarm);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= STOPPED;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_set_ok) begin
      w_state_nxt = COMMIT;
    end else begin
      case (r_state)
        STOPPED: if (bus.run_en)  w_state_nxt = RUN;
        RUN:     if (!bus.run_en) w_state_nxt = STOPPED;
        COMMIT:  w_state_nxt = bus.run_en ? RUN : STOPPED;
        default: w_state_nxt = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre           <= '0;
      r_time          <= '0;
      r_alarm         <= '0;
      r_sec_tick      <= 1'b0;
      r_alarm_irq     <= 1'b0;
      r_alarm_pending <= 1'b0;
      r_set_err       <= 1'b0;
    end else begin
      r_sec_tick  <= 1'b0;
      r_alarm_irq <= w_match;
      r_set_err   <= w_set_bad | w_alarm_bad;

      // An accepted set pre-empts a coincident wrap; that tick is dropped.
      if (w_set_ok) begin
        r_time <= bus.set_time;
        r_pre  <= '0;
      end else if (w_wrap) begin
        r_pre      <= '0;
        r_time     <= w_cur_valid ? w_next_time : '0;
        r_sec_tick <= 1'b1;
      end else if (w_count) begin
        r_pre <= r_pre + PW'(1);
      end

      if (w_alarm_ok) r_alarm <= bus.alarm_time;

      if (w_match)            r_alarm_pending <= 1'b1;
      else if (bus.alarm_clr) r_alarm_pending <= 1'b0;
    end
  end

  assign bus.set_ready     = w_set_ready;
  assign bus.time_out      = r_time;
  assign bus.sec_tick      = r_sec_tick;
  assign bus.alarm_irq     = r_alarm_irq;
  assign bus.alarm_pending = r_alarm_pending;
  assign bus.set_err       = r_set_err;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Directed bench for rtc_ctrl at TICK_DIV=4 with hand-computed expectations.
module tb_rtc_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  rtc_ctrl_if bus ();

  rtc_ctrl #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.run_en     = 1'b0;
    bus.set_valid  = 1'b0;
    bus.set_time   = '0;
    bus.alarm_wr   = 1'b0;
    bus.alarm_time = '0;
    bus.alarm_en   = 1'b0;
    bus.alarm_clr  = 1'b0;

    // Reset values
    step(2);
    chk("rst_time", bus.time_out, 24'h0);
    chk("rst_ready", bus.set_ready, 1);
    chk("rst_tick", bus.sec_tick, 0);
    chk("rst_irq", bus.alarm_irq, 0);
    chk("rst_pend", bus.alarm_pending, 0);
    chk("rst_err", bus.set_err, 0);

    // First tick after 4 cycles, then every 4
    reset_n = 1'b1;
    bus.run_en = 1'b1;
    step(3);
    chk("tick1_early", bus.sec_tick, 0);
    step(1);
    chk("tick1", bus.sec_tick, 1);
    chk("tick1_time", bus.time_out, 24'h000001);
    step(1);
    chk("tick1_pulse", bus.sec_tick, 0);
    step(3);
    chk("tick2", bus.sec_tick, 1);
    chk("tick2_time", bus.time_out, 24'h000002);

    // Day wrap from 23:59:58
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h235958;
    step(1);
    bus.set_valid = 1'b0;
    chk("set1_ready", bus.set_ready, 0);
    chk("set1_time", bus.time_out, 24'h235958);
    step(5);
    chk("wrap_a", bus.time_out, 24'h235959);
    step(4);
    chk("wrap_day_tick", bus.sec_tick, 1);
    chk("wrap_day", bus.time_out, 24'h000000);

    // 19:59:59 -> 20:00:00
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h195959;
    step(1);
    bus.set_valid = 1'b0;
    step(5);
    chk("wrap_20", bus.time_out, 24'h200000);

    // Set in the exact wrap cycle wins over the tick
    step(3);
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h123456;
    step(1);
    bus.set_valid = 1'b0;
    chk("arb_tick", bus.sec_tick, 0);
    chk("arb_time", bus.time_out, 24'h123456);
    chk("arb_ready", bus.set_ready, 0);
    step(1);
    chk("arb_ready2", bus.set_ready, 1);
    chk("arb_tick2", bus.sec_tick, 0);
    step(3);
    chk("arb_tick_early", bus.sec_tick, 0);
    step(1);
    chk("arb_tick_late", bus.sec_tick, 1);
    chk("arb_next", bus.time_out, 24'h123457);

    // Invalid set values rejected without disturbing the prescaler
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h240000;
    step(1);
    bus.set_valid = 1'b0;
    chk("bad24_err", bus.set_err, 1);
    chk("bad24_time", bus.time_out, 24'h123457);
    chk("bad24_ready", bus.set_ready, 1);
    step(1);
    chk("bad24_pulse", bus.set_err, 0);
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h006000;
    step(1);
    bus.set_valid = 1'b0;
    chk("bad60_err", bus.set_err, 1);
    chk("bad60_time", bus.time_out, 24'h123457);
    step(1);
    chk("bad_keep_tick", bus.sec_tick, 1);
    chk("bad_keep_time", bus.time_out, 24'h123458);

    // Alarm at 00:00:03 loaded together with a set to 00:00:00
    bus.alarm_wr   = 1'b1;
    bus.alarm_time = 22'h000003;
    bus.alarm_en   = 1'b1;
    bus.set_valid  = 1'b1;
    bus.set_time   = 22'h000000;
    step(1);
    bus.alarm_wr  = 1'b0;
    bus.set_valid = 1'b0;
    chk("al_set_time", bus.time_out, 24'h000000);
    chk("al_set_err", bus.set_err, 0);
    step(5);
    chk("al_t1", bus.time_out, 24'h000001);
    step(4);
    chk("al_t2_irq", bus.alarm_irq, 0);
    step(4);
    chk("al_t3", bus.time_out, 24'h000003);
    chk("al_t3_irq", bus.alarm_irq, 0);
    step(1);
    chk("al_irq", bus.alarm_irq, 1);
    chk("al_pend", bus.alarm_pending, 1);
    step(1);
    chk("al_irq_pulse", bus.alarm_irq, 0);
    chk("al_pend_hold", bus.alarm_pending, 1);
    bus.alarm_clr = 1'b1;
    step(1);
    bus.alarm_clr = 1'b0;
    chk("al_clr", bus.alarm_pending, 0);
    step(1);
    chk("al_t4", bus.time_out, 24'h000004);

    // Clear coinciding with a new match: match wins
    bus.alarm_wr   = 1'b1;
    bus.alarm_time = 22'h000006;
    step(1);
    bus.alarm_wr = 1'b0;
    step(3);
    chk("al_t5", bus.time_out, 24'h000005);
    step(4);
    chk("al_t6", bus.time_out, 24'h000006);
    bus.alarm_clr = 1'b1;
    step(1);
    chk("al_clr_race_irq", bus.alarm_irq, 1);
    chk("al_clr_race_pend", bus.alarm_pending, 1);
    step(1);
    bus.alarm_clr = 1'b0;
    chk("al_clr2", bus.alarm_pending, 0);

    // Direct set onto the alarm value must not raise the alarm
    bus.alarm_wr   = 1'b1;
    bus.alarm_time = 22'h000003;
    bus.set_valid  = 1'b1;
    bus.set_time   = 22'h000003;
    step(1);
    bus.alarm_wr  = 1'b0;
    bus.set_valid = 1'b0;
    chk("seteq_time", bus.time_out, 24'h000003);
    step(1);
    chk("seteq_irq_a", bus.alarm_irq, 0);
    step(1);
    chk("seteq_irq_b", bus.alarm_irq, 0);
    chk("seteq_pend", bus.alarm_pending, 0);
    step(3);
    chk("seteq_t4", bus.time_out, 24'h000004);
    step(1);
    chk("seteq_t4_irq", bus.alarm_irq, 0);

    // Invalid alarm value flagged
    bus.alarm_wr   = 1'b1;
    bus.alarm_time = 22'h000070;
    step(1);
    bus.alarm_wr = 1'b0;
    chk("bad_alarm_err", bus.set_err, 1);

    // Pause at prescaler 2, resume: tick after 2 cycles
    bus.run_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("pause_tick%0d", i), bus.sec_tick, 0);
    end
    chk("pause_time", bus.time_out, 24'h000004);
    bus.run_en = 1'b1;
    step(1);
    chk("resume_early", bus.sec_tick, 0);
    step(1);
    chk("resume_tick", bus.sec_tick, 1);
    chk("resume_time", bus.time_out, 24'h000005);

    // Asynchronous reset during COMMIT
    bus.set_valid = 1'b1;
    bus.set_time  = 22'h224410;
    step(1);
    bus.set_valid = 1'b0;
    chk("commit_ready", bus.set_ready, 0);
    chk("commit_time", bus.time_out, 24'h224410);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_time", bus.time_out, 24'h0);
    chk("arst_ready", bus.set_ready, 1);
    chk("arst_tick", bus.sec_tick, 0);
    chk("arst_pend", bus.alarm_pending, 0);
    bus.run_en = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(6);
    chk("post_rst_time", bus.time_out, 24'h0);
    chk("post_rst_tick", bus.sec_tick, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
